apb_master_req: RTL
===================

# apb_master_req

Single-outstanding APB3 initiator that converts a valid/ready request/response interface into APB SETUP/ACCESS transfers. It sits between a bus-agnostic requester (debug port, DMA descriptor fetcher, test controller) and the peripheral APB segment carrying `apb_timer` and its siblings. It is the master-side counterpart of those APB responders. It optionally aborts transfers whose responder never asserts `pready_i`.

## Interface
- `APB_ADDR_WIDTH`, 12, width of `req_addr_i` / `paddr_o`
- `TIMEOUT_CYCLES`, 255, ACCESS-phase cycle limit (≥1); used only with the timeout feature
- `pclk_i` in 1: single clock, all logic rising-edge
- `presetn_i` in 1: asynchronous, active-low reset
- `req_valid_i` in 1: request valid
- `req_ready_o` out 1: request accepted when both are high
- `req_addr_i` in APB_ADDR_WIDTH: transfer address
- `req_wdata_i` in 32: write data
- `req_write_i` in 1: 1 = write, 0 = read
- `rsp_valid_o` out 1: response valid
- `rsp_ready_i` in 1: response consumed when both are high
- `rsp_rdata_o` out 32: read data (0 for writes and timeouts)
- `rsp_err_o` out 1: `pslverr_i` captured, or timeout
- `rsp_timeout_o` out 1: response caused by timeout
- `busy_o` out 1: FSM is not in IDLE
- `paddr_o` out APB_ADDR_WIDTH, `pwdata_o` out 32, `pwrite_o` out 1, `psel_o` out 1, `penable_o` out 1: APB master outputs
- `prdata_i` in 32, `pready_i` in 1, `pslverr_i` in 1: APB responder returns

## Operation
- FSM states are IDLE, SETUP, ACCESS and RESP. All state and outputs are registered except `req_ready_o`, `busy_o` and the `psel_o` / `penable_o` decodes.
- **IDLE**
  - `req_ready_o` = 1.
  - On `req_valid_i`: latch addr, wdata and write into the `paddr_o` / `pwdata_o` / `pwrite_o` registers, then go to SETUP.
- **SETUP**
  - `psel_o` = 1, `penable_o` = 0.
  - Unconditionally go to ACCESS.
- **ACCESS**
  - `psel_o` = 1, `penable_o` = 1.
  - On `pready_i` = 1:
    - `rsp_rdata_o` ← `prdata_i` for a read, or 0 for a write.
    - `rsp_err_o` ← `pslverr_i`.
    - `rsp_timeout_o` ← 0.
    - Go to RESP.
  - Otherwise stay in ACCESS.
- **RESP**
  - `rsp_valid_o` = 1 and response fields are held stable.
  - On `rsp_ready_i`: go to IDLE.
- `req_ready_o` is high only in IDLE. Only one transfer is outstanding at any time.
- `paddr_o`, `pwdata_o` and `pwrite_o` stay stable from SETUP through the end of ACCESS. They hold their last value while idle.
- `pslverr_i` and `prdata_i` are sampled only in the ACCESS cycle where `pready_i` = 1.
- Reset mid-transfer: `psel_o`, `penable_o` and `rsp_valid_o` drop immediately and the FSM returns to IDLE. The transfer is lost and no response is generated.

## Timing
- Reset values:
  - FSM = IDLE.
  - `psel_o`, `penable_o`, `rsp_valid_o`, `rsp_err_o`, `rsp_timeout_o` = 0.
  - `paddr_o`, `pwdata_o`, `pwrite_o`, `rsp_rdata_o` = 0.
  - `req_ready_o` = 1 and `busy_o` = 0 once reset is released.
- Minimum latency, with `pready_i` high on the first ACCESS cycle:
  - Accept at cycle N.
  - SETUP at N+1.
  - ACCESS at N+2.
  - `rsp_valid_o` at N+3.
- Throughput: with `rsp_ready_i` held high, the next accept is at N+4 at the earliest, i.e. one transfer per 4 cycles.
- Each `pready_i`-low cycle in ACCESS adds one cycle of latency.
- Back-pressure on `rsp_ready_i` stalls the FSM in RESP. APB stays idle (`psel_o` = 0) while stalled.

## Configuration
- Macro: `APB_MASTER_TIMEOUT_EN`.
- **Defined**
  - A counter of width $clog2(TIMEOUT_CYCLES+1) is cleared on entry to ACCESS and increments on each ACCESS cycle with `pready_i` = 0.
  - If `pready_i` = 0 and the count equals TIMEOUT_CYCLES-1, go to RESP with `rsp_err_o` = 1, `rsp_timeout_o` = 1 and `rsp_rdata_o` = 0.
  - On a timeout, ACCESS lasts exactly TIMEOUT_CYCLES cycles and `psel_o` drops the next cycle.
  - If `pready_i` = 1 in the limit cycle, the transfer completes normally.
- **Not defined**
  - No counter is built and `rsp_timeout_o` is tied to 0.
  - ACCESS waits indefinitely for `pready_i`.

## Test plan
- **Zero-wait read:** addr 0x010, `pready_i` high in ACCESS, `prdata_i` = 0xDEADBEEF.
  - Response at N+3 with rdata 0xDEADBEEF and err 0.
  - `psel_o` high for exactly 2 cycles.
- **Write with 3 wait states:** addr 0x024, wdata 0x12345678.
  - ACCESS lasts 4 cycles and `paddr_o` / `pwdata_o` are stable throughout.
  - Response has rdata 0 and err 0.
- **Slave error:** read with `pslverr_i` = 1 on the `pready_i` cycle.
  - `rsp_err_o` = 1 and `rsp_timeout_o` = 0.
  - The next request is accepted only after the RESP handshake.
- **Response back-pressure:** `rsp_ready_i` held low for 5 cycles.
  - `rsp_valid_o` and data stay stable, `req_ready_o` = 0 and `psel_o` = 0 throughout.
  - The handshake returns the FSM to IDLE.
- **Timeout (macro defined, TIMEOUT_CYCLES = 4):** `pready_i` never asserted.
  - ACCESS lasts 4 cycles, then the response has err 1, timeout 1 and rdata 0.
  - A second run with `pready_i` asserted in the 4th ACCESS cycle completes normally.
- **Reset mid-ACCESS:** `presetn_i` pulled low during ACCESS.
  - `psel_o` and `penable_o` go to 0 without a clock edge.
  - No response is produced; after release `req_ready_o` = 1.

Source files
------------

// File: rtl/apb_master_req.sv
// -----------------------------------------------------------------------------
// apb_master_req
//
// Single-outstanding APB3 initiator. A bus-agnostic requester hands over one
// transfer on a valid/ready request channel; the block runs it as an APB
// SETUP/ACCESS sequence and returns the outcome on a valid/ready response
// channel. A new request is taken only once the previous response has been
// consumed.
//
// Optional feature (compile-time macro APB_MASTER_TIMEOUT_EN):
//   defined   - ACCESS is aborted after TIMEOUT_CYCLES cycles without pready_i,
//               returning an error response flagged as a timeout.
//   undefined - ACCESS waits indefinitely; rsp_timeout_o is constant 0.
//
// Parameters:
//   APB_ADDR_WIDTH  width of req_addr_i / paddr_o
//   TIMEOUT_CYCLES  ACCESS-phase cycle limit (>= 1), timeout build only
//
// Ports:
//   pclk_i, presetn_i      clock (rising edge), async active-low reset
//   req_valid_i/ready_o    request handshake
//   req_addr_i/wdata_i     transfer address / write data
//   req_write_i            1 = write, 0 = read
//   rsp_valid_o/ready_i    response handshake
//   rsp_rdata_o            read data (0 for writes and timeouts)
//   rsp_err_o              pslverr_i captured, or timeout
//   rsp_timeout_o          response produced by the timeout
//   busy_o                 a transfer is in flight (FSM not IDLE)
//   paddr_o .. penable_o   APB master outputs
//   prdata_i, pready_i,
//   pslverr_i              APB responder returns
// -----------------------------------------------------------------------------
module apb_master_req #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      pclk_i,
  input  logic                      presetn_i,
  // request channel
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]               req_wdata_i,
  input  logic                      req_write_i,
  // response channel
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic                      busy_o,
  // APB master side
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [31:0]               pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [31:0]               prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // A zero limit would make the timeout compare against an all-ones count.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master_req: TIMEOUT_CYCLES must be >= 1");
  end

  state_e                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [31:0]               rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      rsp_timeout_q, rsp_timeout_d;
  logic                      timeout_hit;

  // ---------------------------------------------------------------------------
  // ACCESS watchdog
  // ---------------------------------------------------------------------------
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned          CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Cleared during SETUP so it reads 0 in the first ACCESS cycle; the limit
  // cycle is therefore the TIMEOUT_CYCLES-th ACCESS cycle.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == S_SETUP) begin
      wait_cnt_d = '0;
    end else if ((state_q == S_ACCESS) && !pready_i) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // A pready_i in the limit cycle wins: the transfer completes normally.
  assign timeout_hit = (state_q == S_ACCESS) && !pready_i && (wait_cnt_q == CNT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register and output registers
  // ---------------------------------------------------------------------------
  // NOTE: every flop is written with <= so all of them sample the values
  // computed before the edge; a blocking = here would create order-dependent
  // simulation that no longer matches the synthesized netlist.
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state_q       <= S_IDLE;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pwrite_q      <= pwrite_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: each always_comb starts by assigning a default to every signal it
  // drives, so no path through the case leaves a value unassigned and no
  // latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (req_valid_i)                state_d = S_SETUP;
      S_SETUP:                                  state_d = S_ACCESS;
      S_ACCESS: if (pready_i || timeout_hit)    state_d = S_RESP;
      S_RESP:   if (rsp_ready_i)                state_d = S_IDLE;
      default:                                  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output-register next values
  // ---------------------------------------------------------------------------
  always_comb begin
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      S_IDLE: begin
        // APB address/data only move on acceptance, so they are stable
        // across SETUP and ACCESS and hold their last value while idle.
        if (req_valid_i) begin
          paddr_d  = req_addr_i;
          pwdata_d = req_wdata_i;
          pwrite_d = req_write_i;
        end
      end
      S_ACCESS: begin
        if (pready_i) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? 32'd0 : prdata_i;
          rsp_err_d     = pslverr_i;
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = 32'd0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready_o   = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign psel_o        = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign penable_o     = (state_q == S_ACCESS);

  assign paddr_o       = paddr_q;
  assign pwdata_o      = pwdata_q;
  assign pwrite_o      = pwrite_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule
